// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder/subtractor: one digit per clock, LSD first.
// Optional input-digit validity flag built only when BCD_INPUT_CHECK_EN is defined.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                sub,
    input  logic [4*DIGITS-1:0] A,
    input  logic [4*DIGITS-1:0] B,
    output logic [4*DIGITS-1:0] S,
    output logic                C_out,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int W    = 4 * DIGITS;
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    logic [W-1:0]    a_q, b_q, res_q, s_q;
    logic            sub_q, c_q, cout_q, busy_q, done_q;
    logic [IDXW-1:0] idx_q;

    logic [3:0]      bp_d, digit_d;
    logic [4:0]      t_d;
    logic            c_d;
    logic [W-1:0]    res_d;
    logic            last_d;

    // Subtraction uses nine's complement of B plus the initial carry of 1.
    always_comb begin
        bp_d    = sub_q ? (4'd9 - b_q[3:0]) : b_q[3:0];
        t_d     = {1'b0, a_q[3:0]} + {1'b0, bp_d} + {4'd0, c_q};
        c_d     = (t_d > 5'd9);
        digit_d = c_d ? (t_d[3:0] + 4'd6) : t_d[3:0];
        res_d   = (res_q >> 4) | (W'(digit_d) << (W - 4));
        last_d  = (idx_q == IDXW'(DIGITS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            s_q     <= '0;
            sub_q   <= 1'b0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        sub_q   <= sub;
                        c_q     <= sub;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 4;
                    b_q   <= b_q >> 4;
                    c_q   <= c_d;
                    res_q <= res_d;
                    idx_q <= idx_q + IDXW'(1);
                    if (last_d) begin
                        s_q     <= res_d;
                        cout_q  <= c_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef BCD_INPUT_CHECK_EN
    logic err_q, bad_d;

    always_comb begin
        bad_d = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (A[4*i +: 4] > 4'd9 || B[4*i +: 4] > 4'd9) bad_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         err_q <= 1'b0;
        else if (state_q == IDLE && start)  err_q <= bad_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign S     = s_q;
    assign C_out = cout_q;
    assign busy  = busy_q;
    assign done  = done_q;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed self-checking bench for bcd_serial_adder (DIGITS=4).
module tb_bcd_serial_adder;
    logic        clk = 1'b0;
    logic        rst_n, start, sub;
    logic [15:0] A, B, S;
    logic        C_out, busy, done, err;

    int n_chk = 0;
    int n_err = 0;

`ifdef BCD_INPUT_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    bcd_serial_adder #(.DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
        .A(A), .B(B), .S(S), .C_out(C_out),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One operation; if hold, start stays high and operands change during RUN.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [15:0] es, input logic ec,
                          input logic ee, input bit chk_res, input bit hold);
        int          nbusy, cyc;
        bit          s_moved;
        logic [15:0] old_s;
        @(negedge clk);
        A = a; B = b; sub = s; start = 1'b1; old_s = S;
        @(negedge clk);
        if (!hold) start = 1'b0;
        else begin A = 16'h9999; B = 16'h9999; sub = ~s; end
        chk({tag, " err@capture"}, {31'd0, err}, {31'd0, ee});
        nbusy = 0; cyc = 0; s_moved = 0;
        while (!done && cyc < 20) begin
            if (busy) nbusy++;
            if (S !== old_s) s_moved = 1;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({tag, " done seen"}, {31'd0, done}, 32'd1);
        chk({tag, " busy cycles"}, nbusy, 32'd4);
        chk({tag, " S held in RUN"}, {31'd0, s_moved}, 32'd0);
        chk({tag, " busy@done"}, {31'd0, busy}, 32'd0);
        chk({tag, " err@done"}, {31'd0, err}, {31'd0, ee});
        if (chk_res) begin
            chk({tag, " S"}, {16'd0, S}, {16'd0, es});
            chk({tag, " C_out"}, {31'd0, C_out}, {31'd0, ec});
        end
        @(negedge clk);
        chk({tag, " done pulse width"}, {31'd0, done}, 32'd0);
        @(negedge clk);
        chk({tag, " no restart"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int ndone;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; A = '0; B = '0;
        #23;
        chk("reset S", {16'd0, S}, 32'd0);
        chk("reset C_out", {31'd0, C_out}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add1234", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1, 0);
        run_op("add9999+1", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 0);
        run_op("sub5000", 16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b1, 1'b0, 1, 0);
        run_op("sub0001", 16'h0001, 16'h0002, 1'b1, 16'h9999, 1'b0, 1'b0, 1, 0);
        run_op("add9999x2", 16'h9999, 16'h9999, 1'b0, 16'h9998, 1'b1, 1'b0, 1, 0);
        run_op("sub0-0", 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1, 0);
        run_op("hold", 16'h0250, 16'h0750, 1'b0, 16'h1000, 1'b0, 1'b0, 1, 1);
        run_op("add4321", 16'h4321, 16'h1111, 1'b0, 16'h5432, 1'b0, 1'b0, 1, 0);

        // Abort on the second RUN cycle.
        @(negedge clk);
        A = 16'h1111; B = 16'h2222; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort busy before", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort S", {16'd0, S}, 32'd0);
        chk("abort C_out", {31'd0, C_out}, 32'd0);
        chk("abort busy", {31'd0, busy}, 32'd0);
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("abort no done", ndone, 32'd0);
        run_op("after abort", 16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1, 0);

        // Invalid digit: flag only exists with the check build; S is don't-care.
        run_op("bad digit", 16'h00A0, 16'h0000, 1'b0, 16'h0000, 1'b0, ERR_EN, 0, 0);
        run_op("clear err", 16'h0005, 16'h0004, 1'b0, 16'h0009, 1'b0, 1'b0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
